dht11_uart_report: RTL
======================

Name: dht11_uart_report

Overview:
Consumes the 32-bit validated reading from the DHT11 reader and reports it as one ASCII line over a UART transmitter (8N1, LSB first). The input word is {hum_int[31:24], hum_dec[23:16], temp_int[15:8], temp_dec[7:0]}. A frame is sent automatically whenever the reading changes, and on demand through a request pulse. The block sits directly downstream of the DHT11 reader, and its tx pin drives the board UART/USB bridge.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz.
BAUD, 115_200, UART bit rate.
CLKS_PER_BIT, CLK_HZ/BAUD (local, derived), clocks per UART bit; integer division, truncated.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
data_valid  input  32  reading from the DHT11 reader; may change at any clk edge.
send_req  input  1  single-cycle pulse; forces one frame of the current reading.
tx  output  1  UART serial out; idle high.
busy  output  1  high from frame start until the last stop bit ends.
frame_done  output  1  one-cycle pulse in the cycle after the final stop bit of a frame.

Behaviour:
- Reset: tx=1, busy=0, frame_done=0, shadow register=32'h0, pending=0, FSM=IDLE. Reset mid-frame aborts the frame immediately and drives tx high; no partial character is resumed.
- Change detect: trigger when data_valid != shadow. The shadow updates only at LATCH. data_valid stuck at 0 after reset therefore never triggers.
- pending flag: set by send_req or by a change detected while busy. It is cleared at LATCH. Multiple events during one frame collapse into a single follow-up frame.
- Frame format, 17 characters in order: 'H' '=' h2 h1 h0 '.' hd ' ' 'T' '=' t2 t1 t0 '.' td CR LF.
  - h2..h0 are the 3-digit zero-padded decimal of hum_int (0..255).
  - hd is hum_dec mod 10.
  - t2..t0 and td follow the same rules for temp_int and temp_dec.
  - Digit ASCII = 8'h30 + digit.
- FSM states:
  - IDLE: tx=1, busy=0. Leave on a trigger or pending.
  - LATCH (1 cycle): snapshot data_valid into the shadow and into the frame register; busy=1; clear pending.
  - CONVERT: sequential binary-to-decimal conversion of the 4 bytes using repeated subtraction of 100 and 10, or double-dabble. Must finish in 64 cycles or fewer, then go to LOAD with char index=0.
  - LOAD: select character[index] into the shift register.
  - START: tx=0 for CLKS_PER_BIT clocks.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT clocks.
  - STOP: tx=1 for CLKS_PER_BIT clocks. Then: if index==16, go to DONE; else index+1 and go to LOAD.
  - DONE (1 cycle): frame_done=1, busy=0. Return to IDLE.
- Character gap: LOAD contributes exactly 1 clock of idle-high between stop and next start. No other gaps.
- Frame isolation: the frame register is frozen from LATCH to DONE. Input changes mid-frame never alter characters already queued; they only set pending.
- Back-to-back frames: if pending=1 at DONE, the IDLE→LATCH transition occurs on the next cycle. The line stays high at least 2 clocks between frames.
- send_req in the same cycle as a change while IDLE produces one frame, not two.
- Counters:
  - Baud counter: ceil(log2(CLKS_PER_BIT)) bits; wraps to 0 at CLKS_PER_BIT-1.
  - Bit index: 3 bits.
  - Char index: 5 bits, never exceeds 16.

Test Plan:
- CLK_HZ=1_000_000, BAUD=100_000 (10 clk/bit); after reset, hold data_valid=0 for 5000 clk -> tx constantly 1, busy=0, no frame_done.
- Set data_valid=32'h3C00_1905 -> bytes decode to "H=060.0 T=025.5\r\n". Every bit lasts exactly 10 clk. frame_done pulses once. busy drops in that same cycle.
- data_valid=32'hFF0F_0009 -> "H=255.5 T=000.9\r\n", which checks the 3-digit max and the mod-10 decimal.
- Mid-frame (during char 4) change to 32'h2800_1E00 -> first frame still carries the old values intact. Exactly one second frame "H=040.0 T=030.0\r\n" starts within 3 clk after frame_done.
- In IDLE, pulse send_req with data unchanged -> one identical frame. Pulse send_req 3 times during that frame -> exactly one extra frame.
- Assert rst_n low during the DATA state of char 2 -> tx=1, busy=0 immediately (asynchronously). After release, no frame is sent until the next change or send_req.

Source files
------------

// File: rtl/dht11_uart_report_if.sv
// Reading/request inputs and UART status outputs of the DHT11 line reporter.
`timescale 1ns/1ps
interface dht11_uart_report_if;
    logic [31:0] data_valid;
    logic        send_req;
    logic        tx;
    logic        busy;
    logic        frame_done;

    modport master (output data_valid, send_req, input tx, busy, frame_done);
    modport slave  (input data_valid, send_req, output tx, busy, frame_done);
endinterface

// File: rtl/dht11_uart_report.sv
// Formats a DHT11 reading as "H=hhh.h T=ttt.t\r\n" and sends it over an 8N1 UART.
`timescale 1ns/1ps
module dht11_uart_report #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic clk,
    input  logic rst_n,
    dht11_uart_report_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, LATCH, CONVERT, LOAD, START, DATA, STOP, DONE} state_t;
    state_t state, state_nxt;

    logic [31:0]      shadow, frame;
    logic             pending;
    logic [BW-1:0]    baud_cnt;
    logic [2:0]       bit_idx;
    logic [4:0]       char_idx;
    logic [7:0]       shreg;
    logic [7:0]       rem, src_nxt, char_sel;
    logic [3:0]       hcnt, tcnt;
    logic [1:0]       cnv_idx, cnv_nxt;
    logic [3:0][3:0]  units;
    logic [1:0][3:0]  hund, tens;
    logic             change, bit_done, byte_done, busy;

    assign change    = bus.data_valid != shadow;
    assign bit_done  = baud_cnt == BAUD_LAST;
    assign byte_done = rem < 8'd10;
    assign cnv_nxt   = cnv_idx + 2'd1;
    assign busy      = !(state == IDLE || state == DONE);

    assign bus.tx         = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;
    assign bus.busy       = busy;
    assign bus.frame_done = state == DONE;

    function automatic logic [7:0] asc(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    always_comb begin
        src_nxt = frame[31:24];
        case (cnv_nxt)
            2'd1:    src_nxt = frame[23:16];
            2'd2:    src_nxt = frame[15:8];
            2'd3:    src_nxt = frame[7:0];
            default: src_nxt = frame[31:24];
        endcase
    end

    // Byte 0/2 are integer parts (3 digits), bytes 1/3 decimal parts (units only).
    always_comb begin
        char_sel = 8'h0A;
        case (char_idx)
            5'd0:    char_sel = "H";
            5'd1:    char_sel = "=";
            5'd2:    char_sel = asc(hund[0]);
            5'd3:    char_sel = asc(tens[0]);
            5'd4:    char_sel = asc(units[0]);
            5'd5:    char_sel = ".";
            5'd6:    char_sel = asc(units[1]);
            5'd7:    char_sel = " ";
            5'd8:    char_sel = "T";
            5'd9:    char_sel = "=";
            5'd10:   char_sel = asc(hund[1]);
            5'd11:   char_sel = asc(tens[1]);
            5'd12:   char_sel = asc(units[2]);
            5'd13:   char_sel = ".";
            5'd14:   char_sel = asc(units[3]);
            5'd15:   char_sel = 8'h0D;
            default: char_sel = 8'h0A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (change || pending || bus.send_req) state_nxt = LATCH;
            LATCH:   state_nxt = CONVERT;
            CONVERT: if (byte_done && cnv_idx == 2'd3) state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   if (bit_done) state_nxt = DATA;
            DATA:    if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
            STOP:    if (bit_done) state_nxt = (char_idx == 5'd16) ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latching clears pending; any request or mid-frame change collapses into one flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                pending <= 1'b0;
        else if (state == LATCH)                   pending <= 1'b0;
        else if (bus.send_req || (busy && change)) pending <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            frame    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            shreg    <= '0;
            rem      <= '0;
            hcnt     <= '0;
            tcnt     <= '0;
            cnv_idx  <= '0;
            units    <= '0;
            hund     <= '0;
            tens     <= '0;
        end else begin
            case (state)
                LATCH: begin
                    shadow  <= bus.data_valid;
                    frame   <= bus.data_valid;
                    rem     <= bus.data_valid[31:24];
                    cnv_idx <= '0;
                    hcnt    <= '0;
                    tcnt    <= '0;
                end
                CONVERT: begin
                    if (rem >= 8'd100) begin
                        rem  <= rem - 8'd100;
                        hcnt <= hcnt + 4'd1;
                    end else if (rem >= 8'd10) begin
                        rem  <= rem - 8'd10;
                        tcnt <= tcnt + 4'd1;
                    end else begin
                        units[cnv_idx] <= rem[3:0];
                        if (!cnv_idx[0]) begin
                            hund[cnv_idx[1]] <= hcnt;
                            tens[cnv_idx[1]] <= tcnt;
                        end
                        hcnt     <= '0;
                        tcnt     <= '0;
                        cnv_idx  <= cnv_nxt;
                        rem      <= src_nxt;
                        char_idx <= '0;
                    end
                end
                LOAD: begin
                    shreg    <= char_sel;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                end
                START, DATA, STOP: begin
                    baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
                    if (state == DATA && bit_done) begin
                        shreg   <= {1'b1, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                    if (state == STOP && bit_done && char_idx != 5'd16)
                        char_idx <= char_idx + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
